// File: rtl/voice_alloc_if.sv
// Note event handshake between a sequencer and the voice allocator.
interface voice_alloc_if #(
  parameter int NUM_BITS  = 32,
  parameter int NOTE_BITS = 7
);
  logic                 ev_valid;
  logic                 ev_ready;
  logic                 ev_on;
  logic [NOTE_BITS-1:0] ev_note;
  logic [NUM_BITS-1:0]  ev_word;

  modport master (
    output ev_valid, ev_on, ev_note, ev_word,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_word,
    output ev_ready
  );
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: scans the channel table once per event and
// retriggers, fills a free channel, or steals round-robin.
module voice_alloc #(
  parameter int NUM_BITS     = 32,
  parameter int NUM_CHANNELS = 16,
  parameter int NOTE_BITS    = 7
) (
  input  logic                             clk,
  input  logic                             rst_n,
  voice_alloc_if.slave                     ev,
  output logic [NUM_CHANNELS-1:0]          gate,
  output logic [NUM_CHANNELS-1:0]          load,
  output logic [NUM_CHANNELS*NUM_BITS-1:0] tuning_words,
  output logic                             steal
);

  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    lat_on_q, lat_on_d;
  logic [NOTE_BITS-1:0]    lat_note_q, lat_note_d;
  logic [NUM_BITS-1:0]     lat_word_q, lat_word_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        steal_ptr_q, steal_ptr_d;
  logic                    hit_found_q, hit_found_d;
  logic [IDX_W-1:0]        hit_idx_q, hit_idx_d;
  logic                    free_found_q, free_found_d;
  logic [IDX_W-1:0]        free_idx_q, free_idx_d;
  logic [NUM_CHANNELS-1:0] gate_q, gate_d;
  logic [NUM_CHANNELS-1:0] load_q, load_d;
  logic                    steal_q, steal_d;
  logic [NOTE_BITS-1:0]    note_q [NUM_CHANNELS];
  logic [NOTE_BITS-1:0]    note_d [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     word_q [NUM_CHANNELS];
  logic [NUM_BITS-1:0]     word_d [NUM_CHANNELS];
  logic [IDX_W-1:0]        target;

  always_comb begin
    state_d      = state_q;
    lat_on_d     = lat_on_q;
    lat_note_d   = lat_note_q;
    lat_word_d   = lat_word_q;
    idx_d        = idx_q;
    steal_ptr_d  = steal_ptr_q;
    hit_found_d  = hit_found_q;
    hit_idx_d    = hit_idx_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    gate_d       = gate_q;
    note_d       = note_q;
    word_d       = word_q;
    load_d       = '0;
    steal_d      = 1'b0;
    target       = '0;

    case (state_q)
      IDLE: begin
        if (ev.ev_valid && ready_q) begin
          lat_on_d     = ev.ev_on;
          lat_note_d   = ev.ev_note;
          lat_word_d   = ev.ev_word;
          idx_d        = '0;
          hit_found_d  = 1'b0;
          hit_idx_d    = '0;
          free_found_d = 1'b0;
          free_idx_d   = '0;
          state_d      = SCAN;
        end
      end

      SCAN: begin
        // Only the first match of each kind is kept, giving lowest-index priority.
        if (gate_q[idx_q] && (note_q[idx_q] == lat_note_q) && !hit_found_q) begin
          hit_found_d = 1'b1;
          hit_idx_d   = idx_q;
        end
        if (!gate_q[idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      COMMIT: begin
        if (lat_on_q && (lat_word_q != '0)) begin
          if (hit_found_q) begin
            target = hit_idx_q;
          end else if (free_found_q) begin
            target = free_idx_q;
          end else begin
            target      = steal_ptr_q;
            steal_d     = 1'b1;
            steal_ptr_d = (steal_ptr_q == LAST_IDX) ? '0 : steal_ptr_q + IDX_W'(1);
          end
          gate_d[target] = 1'b1;
          note_d[target] = lat_note_q;
          word_d[target] = lat_word_q;
          load_d[target] = 1'b1;
        end else if (hit_found_q) begin
          // Release keeps note and word so the generator can play its tail.
          gate_d[hit_idx_q] = 1'b0;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      lat_on_q     <= 1'b0;
      lat_note_q   <= '0;
      lat_word_q   <= '0;
      idx_q        <= '0;
      steal_ptr_q  <= '0;
      hit_found_q  <= 1'b0;
      hit_idx_q    <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      gate_q       <= '0;
      load_q       <= '0;
      steal_q      <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        note_q[c] <= '0;
        word_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      lat_on_q     <= lat_on_d;
      lat_note_q   <= lat_note_d;
      lat_word_q   <= lat_word_d;
      idx_q        <= idx_d;
      steal_ptr_q  <= steal_ptr_d;
      hit_found_q  <= hit_found_d;
      hit_idx_q    <= hit_idx_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      gate_q       <= gate_d;
      load_q       <= load_d;
      steal_q      <= steal_d;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        note_q[c] <= note_d[c];
        word_q[c] <= word_d[c];
      end
    end
  end

  assign ev.ev_ready = ready_q;
  assign gate        = gate_q;
  assign load        = load_q;
  assign steal       = steal_q;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_words
    assign tuning_words[gi*NUM_BITS +: NUM_BITS] = word_q[gi];
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus randomized
// events checked against a channel-table reference model.
module tb_voice_alloc;
  localparam int NB  = 32;
  localparam int NC  = 4;
  localparam int NTB = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NC-1:0]    gate;
  logic [NC-1:0]    load;
  logic [NC*NB-1:0] tuning_words;
  logic             steal;

  voice_alloc_if #(.NUM_BITS(NB), .NOTE_BITS(NTB)) ev_if ();

  voice_alloc #(.NUM_BITS(NB), .NUM_CHANNELS(NC), .NOTE_BITS(NTB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ev           (ev_if.slave),
    .gate         (gate),
    .load         (load),
    .tuning_words (tuning_words),
    .steal        (steal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the channel table as plain arrays.
  bit             m_gate [NC];
  logic [NTB-1:0] m_note [NC];
  logic [NB-1:0]  m_word [NC];
  int             m_ptr;
  logic [NC-1:0]  exp_load;
  logic           exp_steal;

  // Observations from the most recent event.
  logic [NC-1:0] obs_load, obs_load_pre, obs_load_after;
  logic          obs_steal, obs_steal_after, obs_ready_pre, obs_ready_post, obs_gate_moved;

  function automatic logic [NC-1:0] m_gate_vec();
    logic [NC-1:0] v;
    for (int c = 0; c < NC; c++) v[c] = m_gate[c];
    return v;
  endfunction

  function automatic logic [NC*NB-1:0] m_words_vec();
    logic [NC*NB-1:0] v;
    for (int c = 0; c < NC; c++) v[c*NB +: NB] = m_word[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_gate[c] = 1'b0;
      m_note[c] = '0;
      m_word[c] = '0;
    end
    m_ptr = 0;
  endtask

  task automatic model_event(input bit on, input logic [NTB-1:0] note, input logic [NB-1:0] word);
    int hit = -1;
    int free = -1;
    int t;
    exp_load  = '0;
    exp_steal = 1'b0;
    for (int c = 0; c < NC; c++) begin
      if (m_gate[c] && m_note[c] == note && hit < 0) hit = c;
      if (!m_gate[c] && free < 0) free = c;
    end
    if (on && word != 0) begin
      if (hit >= 0) t = hit;
      else if (free >= 0) t = free;
      else begin
        t = m_ptr;
        exp_steal = 1'b1;
        m_ptr = (m_ptr + 1) % NC;
      end
      m_gate[t] = 1'b1;
      m_note[t] = note;
      m_word[t] = word;
      exp_load[t] = 1'b1;
    end else if (hit >= 0) begin
      m_gate[hit] = 1'b0;
    end
  endtask

  task automatic do_event(input bit on, input logic [NTB-1:0] note, input logic [NB-1:0] word);
    int w = 0;
    logic [NC-1:0] g0;
    while (ev_if.ev_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (w >= 50) begin
      failures++;
      $display("FAIL ready_wait ev_ready got %b required 1 within 50 cycles", ev_if.ev_ready);
    end
    g0 = gate;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = note;
    ev_if.ev_word  = word;
    @(posedge clk); #1;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'($urandom);
    ev_if.ev_note  = NTB'($urandom);
    ev_if.ev_word  = $urandom;
    obs_load_pre   = '0;
    obs_gate_moved = 1'b0;
    for (int k = 1; k <= NC; k++) begin
      @(posedge clk); #1;
      obs_load_pre = obs_load_pre | load;
      if (gate !== g0) obs_gate_moved = 1'b1;
    end
    obs_ready_pre = ev_if.ev_ready;
    @(posedge clk); #1;
    obs_load       = load;
    obs_steal      = steal;
    obs_ready_post = ev_if.ev_ready;
    @(posedge clk); #1;
    obs_load_after  = load;
    obs_steal_after = steal;
  endtask

  task automatic apply_reset();
    ev_if.ev_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on = 1'b0;
    ev_if.ev_note = '0;
    ev_if.ev_word = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ev_if.ev_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got %b required 0", ev_if.ev_ready); end
    checks++;
    if (gate !== '0 || load !== '0 || steal !== 1'b0) begin
      failures++; $display("FAIL reset_outputs gate=%b load=%b steal=%b required all 0", gate, load, steal);
    end
    checks++;
    if (tuning_words !== '0) begin failures++; $display("FAIL reset_words got %h required 0", tuning_words); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ev_if.ev_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got %b required 1", ev_if.ev_ready); end
    model_reset();
  endtask

  task automatic test_first_note();
    do_event(1'b1, 7'd60, 32'h0100_0000);
    model_event(1'b1, 7'd60, 32'h0100_0000);
    checks++;
    if (obs_load !== 4'b0001 || obs_steal !== 1'b0) begin
      failures++; $display("FAIL first_load load=%b steal=%b required 0001/0", obs_load, obs_steal);
    end
    checks++;
    if (gate !== 4'b0001 || tuning_words[0 +: NB] !== 32'h0100_0000) begin
      failures++; $display("FAIL first_state gate=%b word0=%h required 0001/01000000", gate, tuning_words[0 +: NB]);
    end
    checks++;
    if (obs_ready_pre !== 1'b0 || obs_ready_post !== 1'b1 || obs_load_pre !== '0 || obs_load_after !== '0) begin
      failures++;
      $display("FAIL first_timing ready_pre=%b ready_post=%b load_pre=%b load_after=%b required 0/1/0000/0000",
               obs_ready_pre, obs_ready_post, obs_load_pre, obs_load_after);
    end
  endtask

  task automatic test_fill_and_release();
    logic [NTB-1:0] notes [3] = '{7'd62, 7'd64, 7'd65};
    for (int i = 0; i < 3; i++) begin
      do_event(1'b1, notes[i], 32'h0110_0000 + NB'(i));
      model_event(1'b1, notes[i], 32'h0110_0000 + NB'(i));
      checks++;
      if (obs_load !== exp_load || gate !== m_gate_vec() || tuning_words !== m_words_vec()) begin
        failures++; $display("FAIL fill_%0d load=%b gate=%b required %b/%b", i, obs_load, gate, exp_load, m_gate_vec());
      end
    end
    checks++;
    if (gate !== 4'b1111) begin failures++; $display("FAIL fill_full gate=%b required 1111", gate); end
    do_event(1'b0, 7'd62, 32'hDEAD_BEEF);
    model_event(1'b0, 7'd62, 32'hDEAD_BEEF);
    checks++;
    if (gate !== 4'b1101 || obs_load !== '0 || obs_steal !== 1'b0) begin
      failures++; $display("FAIL release gate=%b load=%b steal=%b required 1101/0000/0", gate, obs_load, obs_steal);
    end
    checks++;
    if (tuning_words[NB +: NB] !== 32'h0110_0000) begin
      failures++; $display("FAIL release_tail word1=%h required 01100000", tuning_words[NB +: NB]);
    end
  endtask

  task automatic test_steal();
    logic [NTB-1:0] notes [3] = '{7'd66, 7'd67, 7'd69};
    logic [NC-1:0]  lit_load [3] = '{4'b0010, 4'b0001, 4'b0010};
    logic           lit_steal [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_event(1'b1, notes[i], 32'h0300_0000 + NB'(i));
      model_event(1'b1, notes[i], 32'h0300_0000 + NB'(i));
      checks++;
      if (obs_load !== lit_load[i] || obs_steal !== lit_steal[i] || obs_load !== exp_load || obs_steal !== exp_steal) begin
        failures++;
        $display("FAIL steal_%0d load=%b steal=%b required %b/%b", i, obs_load, obs_steal, lit_load[i], lit_steal[i]);
      end
      checks++;
      if (gate !== 4'b1111 || tuning_words !== m_words_vec() || obs_steal_after !== 1'b0) begin
        failures++; $display("FAIL steal_state_%0d gate=%b steal_after=%b required 1111/0", i, gate, obs_steal_after);
      end
    end
  endtask

  task automatic test_retrigger();
    apply_reset();
    do_event(1'b1, 7'd60, 32'h0100_0000);
    model_event(1'b1, 7'd60, 32'h0100_0000);
    do_event(1'b1, 7'd62, 32'h0120_0000);
    model_event(1'b1, 7'd62, 32'h0120_0000);
    do_event(1'b1, 7'd60, 32'h0200_0000);
    model_event(1'b1, 7'd60, 32'h0200_0000);
    checks++;
    if (obs_load !== 4'b0001 || obs_steal !== 1'b0) begin
      failures++; $display("FAIL retrig_load load=%b steal=%b required 0001/0", obs_load, obs_steal);
    end
    checks++;
    if (gate !== 4'b0011 || tuning_words !== m_words_vec() || tuning_words[0 +: NB] !== 32'h0200_0000) begin
      failures++; $display("FAIL retrig_state gate=%b words=%h required 0011/%h", gate, tuning_words, m_words_vec());
    end
  endtask

  task automatic test_zero_word_and_unheld();
    logic [NC-1:0]    g_snap;
    logic [NC*NB-1:0] w_snap;
    do_event(1'b1, 7'd60, 32'h0);
    model_event(1'b1, 7'd60, 32'h0);
    checks++;
    if (gate[0] !== 1'b0 || obs_load !== '0 || gate !== m_gate_vec() || tuning_words !== m_words_vec()) begin
      failures++; $display("FAIL zero_word gate=%b load=%b required %b/0000", gate, obs_load, m_gate_vec());
    end
    g_snap = gate;
    w_snap = tuning_words;
    do_event(1'b0, 7'd70, 32'h1234_5678);
    model_event(1'b0, 7'd70, 32'h1234_5678);
    checks++;
    if (gate !== g_snap || tuning_words !== w_snap || obs_load !== '0 || obs_steal !== 1'b0) begin
      failures++; $display("FAIL unheld_off gate=%b load=%b steal=%b required %b/0000/0", gate, obs_load, obs_steal, g_snap);
    end
    checks++;
    if (obs_ready_pre !== 1'b0 || obs_ready_post !== 1'b1) begin
      failures++; $display("FAIL unheld_timing ready_pre=%b ready_post=%b required 0/1", obs_ready_pre, obs_ready_post);
    end
  endtask

  task automatic test_random();
    bit             on;
    logic [NTB-1:0] n;
    logic [NB-1:0]  w;
    for (int i = 0; i < 40; i++) begin
      on = ($urandom_range(0, 99) < 65);
      n  = NTB'(60 + $urandom_range(0, 5));
      w  = ($urandom_range(0, 9) == 0) ? '0 : NB'($urandom);
      do_event(on, n, w);
      model_event(on, n, w);
      checks++;
      if (obs_load !== exp_load || obs_steal !== exp_steal) begin
        failures++;
        $display("FAIL rand_%0d_pulse on=%b note=%0d load=%b steal=%b required %b/%b",
                 i, on, n, obs_load, obs_steal, exp_load, exp_steal);
      end
      checks++;
      if (gate !== m_gate_vec() || tuning_words !== m_words_vec()) begin
        failures++; $display("FAIL rand_%0d_state gate=%b required %b words=%h required %h",
                             i, gate, m_gate_vec(), tuning_words, m_words_vec());
      end
      checks++;
      if (obs_gate_moved || obs_load_pre !== '0 || obs_load_after !== '0 || obs_steal_after !== 1'b0 ||
          obs_ready_pre !== 1'b0 || obs_ready_post !== 1'b1) begin
        failures++;
        $display("FAIL rand_%0d_timing moved=%b load_pre=%b load_after=%b ready_pre=%b ready_post=%b required 0/0000/0000/0/1",
                 i, obs_gate_moved, obs_load_pre, obs_load_after, obs_ready_pre, obs_ready_post);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int  accepts = 0;
    int  w = 0;
    bit  acc;
    while (ev_if.ev_ready !== 1'b1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b1;
    ev_if.ev_note  = 7'd50;
    ev_if.ev_word  = 32'h0AAA_5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gate !== '0 || load !== '0 || steal !== 1'b0 || tuning_words !== '0 || ev_if.ev_ready !== 1'b0) begin
      failures++; $display("FAIL async_reset gate=%b load=%b steal=%b ready=%b required all 0",
                           gate, load, steal, ev_if.ev_ready);
    end
    model_reset();
    repeat (NC + 2) @(posedge clk);
    #1;
    checks++;
    if (gate !== '0 || load !== '0 || ev_if.ev_ready !== 1'b0) begin
      failures++; $display("FAIL reset_hold gate=%b load=%b ready=%b required 0000/0000/0", gate, load, ev_if.ev_ready);
    end
    rst_n = 1'b1;
    model_event(1'b1, 7'd50, 32'h0AAA_5555);
    for (int k = 0; k < 3 * (NC + 2); k++) begin
      acc = ev_if.ev_valid && ev_if.ev_ready;
      @(posedge clk);
      if (acc) accepts++;
      #1;
      if (acc) ev_if.ev_valid = 1'b0;
    end
    ev_if.ev_valid = 1'b0;
    checks++;
    if (accepts != 1) begin failures++; $display("FAIL accept_count got %0d required 1", accepts); end
    checks++;
    if (gate !== m_gate_vec() || tuning_words !== m_words_vec()) begin
      failures++; $display("FAIL post_reset_commit gate=%b words=%h required %b/%h",
                           gate, tuning_words, m_gate_vec(), m_words_vec());
    end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_fill_and_release();
    test_steal();
    test_retrigger();
    test_zero_word_and_unheld();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator and scheduler for the FM synthesizer's bank of NUM_CHANNELS trigger/phase generators. It accepts note-on/note-off events through a valid/ready handshake and scans the channel table sequentially. It assigns each note to a channel: retrigger, free, or stolen. For every channel it drives the gate, tuning word and a one-cycle reload pulse that the per-channel generators use as their enable.

## Interface
- NUM_BITS, 32, tuning word width; matches the generator accumulators.
- NUM_CHANNELS, 16, voice count; must be ≥2.
- NOTE_BITS, 7, note number width.
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_BITS  note number.
- ev_word  in  NUM_BITS  unsigned tuning word for note-on; ignored for note-off.
- gate  out  NUM_CHANNELS  per-channel note held.
- load  out  NUM_CHANNELS  one-cycle pulse; the channel's tuning word was just written.
- tuning_words  out  NUM_CHANNELS*NUM_BITS  flattened; channel c occupies bits [c*NUM_BITS +: NUM_BITS].
- steal  out  1  one-cycle pulse when a note-on took a busy channel.

## Operation
- Per-channel registers: gate_r, note_r[NOTE_BITS], word_r[NUM_BITS]. Global registers: steal_ptr (mod NUM_CHANNELS), event latch, scan index idx, state.
- FSM states: IDLE, SCAN and COMMIT.
  - IDLE: ev_ready=1. On ev_valid, latch ev_on/ev_note/ev_word, set idx=0 and go to SCAN.
  - SCAN: evaluate channel idx each cycle and increment idx. After idx=NUM_CHANNELS-1, go to COMMIT.
  - COMMIT: write the target channel, pulse load/steal as required, then return to IDLE.
- Scan records the lowest-index match of each kind:
  - hit: gate_r=1 and note_r==latched note.
  - free: gate_r=0.
- A note-on with ev_word≠0 selects its target in this order:
  - The hit channel, if any (retrigger); no steal.
  - Otherwise the free channel, if any.
  - Otherwise the channel at steal_ptr. Assert steal and increment steal_ptr, wrapping NUM_CHANNELS-1→0.
  - Write word_r, note_r and gate_r=1 to the target, and pulse load[target].
- A note-on with ev_word==0 is handled exactly as a note-off for that note.
- Note-off: if there is a hit, clear gate_r at the hit channel and keep word_r and note_r (release tail). If there is no hit, the event is dropped with no output change. No load or steal pulse occurs in either case.
- Only one channel changes per event. Note-offs never change steal_ptr.
- tuning_words and gate are direct register outputs. load and steal are registered pulses.

## Timing
- Reset (async assert) values:
  - state=IDLE, ev_ready=0 while rst_n=0.
  - gate=0, load=0, steal=0, tuning_words=0, steal_ptr=0, all note_r=0.
- First ev_ready=1 in the first cycle after rst_n deasserts.
- Reset asserted mid-scan aborts the event. No partial commit is visible and the event is lost.
- Timing for an event accepted at edge E0 (ev_valid & ev_ready sampled high):
  - ev_ready=0 from E0.
  - SCAN covers edges E1..E_N, with N=NUM_CHANNELS.
  - COMMIT writes at edge E_{N+1}. gate, tuning_words, load and steal update there; load and steal are high for exactly the cycle after E_{N+1}.
  - ev_ready=1 again after E_{N+1}.
- Maximum throughput is one event per N+2 cycles. ev_ready never depends combinationally on ev_valid.
- Event inputs are sampled only at E0. Changes during SCAN/COMMIT are ignored.
- Outputs hold between events. load is 0 outside COMMIT's following cycle.

## Test plan
- Bench parameter NUM_CHANNELS=4 unless stated.
- Reset then note-on (note 60, word 0x0100_0000) -> after 6 cycles: gate=0001, channel 0 word=0x0100_0000, load=0001 for one cycle, steal=0, ev_ready returns high.
- Note-on 60, 62, 64, 65, then note-off 62 -> gate=1111, then 1101. Channel 1 word is retained, and no load pulse is issued on the note-off.
- Four held notes plus note-on 67, then note-on 69 -> first event takes channel 0 (steal=1, steal_ptr→1), second takes channel 1 (steal=1). gate stays 1111 and words are updated.
- Retrigger: note 60 held on channel 0, note-on 60 with a new word 0x0200_0000 -> channel 0 is rewritten with load=0001 and steal=0. No other channel changes.
- Note-on 60 with ev_word=0 while 60 is held -> gate[0] clears and there is no load. A note-off for unheld note 70 -> no output change, and ev_ready returns high after 6 cycles.
- Assert rst_n low during SCAN of a note-on -> all outputs 0 immediately (async), no commit. Hold ev_valid high across reset and verify that exactly one acceptance occurs after release.
